sobel_stream_filter: RTL and testbench

Parametrised streaming 3x3 Sobel filter for raster-order grayscale video. It sits between the grayscale converter and the display/frame-buffer writer. It extends the fixed 640x480, 12-bit edge filter with four things: configurable frame size and pixel width, a run-time mode (horizontal, vertical, magnitude, bypass), ready/valid back-pressure, and a self-timed end-of-frame flush so every input pixel produces exactly one output pixel.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 35 +++
 rtl/sobel_stream_filter.sv | 172 +++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, kernel weights and helpers for the Sobel stream filter
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_H      = 2'd0,
    MODE_V      = 2'd1,
    MODE_MAG    = 2'd2,
    MODE_BYPASS = 2'd3
  } sobel_mode_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sobel_state_e;

  localparam int SOBEL_K0 = 1;
  localparam int SOBEL_K1 = 2;
  localparam int SOBEL_K2 = 1;

  function automatic logic [31:0] sobel_abs(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - WIDTH-deep pixel delay line with shift enable
module sobel_line_buffer #(
  parameter int WIDTH = 640,
  parameter int PIX_W = 12
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = $clog2(WIDTH);

  logic [PIX_W-1:0] mem [WIDTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot yields the sample written WIDTH shifts ago.
  assign dout = mem[ptr];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(WIDTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel filter with back-pressure and end-of-frame flush
// Optional saturation of filtered results is enabled by defining SOBEL_SAT_EN.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 12
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [1:0]                iMODE,
  input  logic                      iDVAL,
  input  logic [PIX_W-1:0]          iDATA,
  output logic                      oREADY,
  output logic                      oDVAL,
  output logic [PIX_W-1:0]          oDATA,
  output logic [$clog2(WIDTH)-1:0]  oX,
  output logic [$clog2(HEIGHT)-1:0] oY,
  output logic                      oSOF,
  output logic                      oEOF
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int GW = PIX_W + 3;
  localparam int RW = PIX_W + 4;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic signed [GW-1:0] KW0 = GW'(SOBEL_K0);
  localparam logic signed [GW-1:0] KW1 = GW'(SOBEL_K1);
  localparam logic signed [GW-1:0] KW2 = GW'(SOBEL_K2);

  sobel_state_e state;
  sobel_mode_e  mode_q;
  logic [XW-1:0] in_x, c_x;
  logic [YW-1:0] in_y, c_y;
  logic accept, flushing, shift, emit, in_last, c_last;
  logic [PIX_W-1:0] din, lb0_q, lb1_q, centre;
  logic [PIX_W-1:0] win_r [3];
  logic [PIX_W-1:0] win_m [3];
  logic [PIX_W-1:0] new_col [3];
  logic [PIX_W-1:0] tap [3][3];
  logic signed [GW-1:0] tx [3][3];
  logic signed [GW-1:0] gx, gy;
  logic [RW-1:0] abs_x, abs_y, mag;
  logic [PIX_W-1:0] reduced, result;
  logic left_edge, right_edge, top_edge, bot_edge;

  assign oREADY   = (state != ST_FLUSH);
  assign flushing = (state == ST_FLUSH);
  assign accept   = iDVAL && oREADY;
  assign shift    = accept || flushing;
  assign emit     = (accept && state == ST_RUN) || flushing;
  assign din      = flushing ? '0 : iDATA;
  assign in_last  = (in_x == X_LAST) && (in_y == Y_LAST);
  assign c_last   = (c_x == X_LAST) && (c_y == Y_LAST);

  sobel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .iCLK(iCLK), .iRST(iRST), .en(shift), .din(din), .dout(lb0_q)
  );
  sobel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .iCLK(iCLK), .iRST(iRST), .en(shift), .din(lb0_q), .dout(lb1_q)
  );

  // Window is evaluated on the column arriving this cycle so the result registers on the accept edge.
  always_ff @(posedge iCLK) begin
    if (shift) begin
      win_m <= win_r;
      win_r <= new_col;
    end
  end

  assign new_col[0] = lb1_q;
  assign new_col[1] = lb0_q;
  assign new_col[2] = din;
  assign centre     = win_r[1];
  assign left_edge  = (c_x == '0);
  assign right_edge = (c_x == X_LAST);
  assign top_edge   = (c_y == '0);
  assign bot_edge   = (c_y == Y_LAST);

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      tap[r][0] = (left_edge || (r == 0 && top_edge) || (r == 2 && bot_edge)) ? centre : win_m[r];
      tap[r][1] = ((r == 0 && top_edge) || (r == 2 && bot_edge)) ? centre : win_r[r];
      tap[r][2] = (right_edge || (r == 0 && top_edge) || (r == 2 && bot_edge)) ? centre : new_col[r];
      for (int c = 0; c < 3; c++) begin
        tx[r][c] = $signed({3'b000, tap[r][c]});
      end
    end
  end

  always_comb begin
    gx = (tx[0][2] * KW0 + tx[1][2] * KW1 + tx[2][2] * KW2)
       - (tx[0][0] * KW0 + tx[1][0] * KW1 + tx[2][0] * KW2);
    gy = (tx[0][0] * KW0 + tx[0][1] * KW1 + tx[0][2] * KW2)
       - (tx[2][0] * KW0 + tx[2][1] * KW1 + tx[2][2] * KW2);
  end

  assign abs_x = RW'(sobel_abs(32'(gx)));
  assign abs_y = RW'(sobel_abs(32'(gy)));

  always_comb begin
    case (mode_q)
      MODE_H:   mag = abs_y;
      MODE_V:   mag = abs_x;
      MODE_MAG: mag = abs_x + abs_y;
      default:  mag = '0;
    endcase
  end

`ifdef SOBEL_SAT_EN
  assign reduced = (mag > RW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
`else
  logic unused_mag_hi;
  assign unused_mag_hi = ^mag[RW-1:PIX_W];
  assign reduced = mag[PIX_W-1:0];
`endif

  assign result = (mode_q == MODE_BYPASS) ? centre : reduced;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= ST_FILL;
      mode_q <= MODE_H;
      in_x   <= '0;
      in_y   <= '0;
      c_x    <= '0;
      c_y    <= '0;
      oDVAL  <= 1'b0;
      oDATA  <= '0;
      oX     <= '0;
      oY     <= '0;
      oSOF   <= 1'b0;
      oEOF   <= 1'b0;
    end else begin
      oDVAL <= emit;
      oSOF  <= emit && left_edge && top_edge;
      oEOF  <= emit && c_last;
      if (emit) begin
        oDATA <= result;
        oX    <= c_x;
        oY    <= c_y;
        if (c_x == X_LAST) begin
          c_x <= '0;
          c_y <= (c_y == Y_LAST) ? '0 : c_y + YW'(1);
        end else begin
          c_x <= c_x + XW'(1);
        end
      end
      if (accept) begin
        if (in_x == '0 && in_y == '0) begin
          mode_q <= sobel_mode_e'(iMODE);
        end
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
        end else begin
          in_x <= in_x + XW'(1);
        end
      end
      case (state)
        ST_FILL:  if (accept && in_x == '0 && in_y == YW'(1)) state <= ST_RUN;
        ST_RUN:   if (accept && in_last) state <= ST_FLUSH;
        ST_FLUSH: if (c_last) state <= ST_FILL;
        default:  state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - self-checking bench, 8x4 frames at 10-bit and 8-bit pixel widths
module tb_sobel_stream_filter;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
`ifdef SOBEL_SAT_EN
  localparam int B400 = 255;
  localparam int B800 = 255;
`else
  localparam int B400 = 144;
  localparam int B800 = 32;
`endif

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [1:0] iMODE = 2'd0;
  logic       iDVAL = 1'b0;
  logic [9:0] da = '0;
  logic [7:0] db;
  assign db = da[7:0];

  logic       rdy_a, dv_a, sof_a, eof_a, rdy_b, dv_b, sof_b, eof_b;
  logic [9:0] d_a;
  logic [7:0] d_b;
  logic [2:0] x_a, x_b;
  logic [1:0] y_a, y_b;

  sobel_stream_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(10)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iDVAL(iDVAL), .iDATA(da),
    .oREADY(rdy_a), .oDVAL(dv_a), .oDATA(d_a), .oX(x_a), .oY(y_a), .oSOF(sof_a), .oEOF(eof_a)
  );
  sobel_stream_filter #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iDVAL(iDVAL), .iDATA(db),
    .oREADY(rdy_b), .oDVAL(dv_b), .oDATA(d_b), .oX(x_b), .oY(y_b), .oSOF(sof_b), .oEOF(eof_b)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;
  int fr_pix [16][N];
  int fr_mode [16];
  int wr_f = 0, rd_f = 0, out_idx = 0, outs = 0;
  int cap_a [N];
  int cap_b [N];
  int low_run = 0;
  int runs [$];

  typedef struct {
    int pat;
    int mode;
    int col;
    int row;
    int exp_a;
    int exp_b;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tapv(int f, int cx, int cy, int r, int c, int mask);
    int xx, yy;
    xx = cx + c - 1;
    yy = cy + r - 1;
    if (xx < 0 || xx >= W || yy < 0 || yy >= H) return fr_pix[f][cy * W + cx] & mask;
    return fr_pix[f][yy * W + xx] & mask;
  endfunction

  function automatic int model_px(int f, int cx, int cy, int pw);
    int mask, gx, gy, ax, ay, v, wt;
    mask = (1 << pw) - 1;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      wt = (i == 1) ? 2 : 1;
      gx += wt * (tapv(f, cx, cy, i, 2, mask) - tapv(f, cx, cy, i, 0, mask));
      gy += wt * (tapv(f, cx, cy, 0, i, mask) - tapv(f, cx, cy, 2, i, mask));
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (fr_mode[f])
      0: v = ay;
      1: v = ax;
      2: v = ax + ay;
      default: return tapv(f, cx, cy, 1, 1, mask);
    endcase
`ifdef SOBEL_SAT_EN
    return (v > mask) ? mask : v;
`else
    return v & mask;
`endif
  endfunction

  always @(negedge iCLK) begin
    int f, cx, cy;
    if (!rdy_a) low_run++;
    else if (low_run > 0) begin
      runs.push_back(low_run);
      low_run = 0;
    end
    if (dv_a) begin
      chk("frame_pending", int'(rd_f != wr_f), 1);
      if (rd_f != wr_f) begin
        f = rd_f % 16;
        cx = out_idx % W;
        cy = out_idx / W;
        chk($sformatf("a_data(%0d,%0d)", cx, cy), int'(d_a), model_px(f, cx, cy, 10));
        chk($sformatf("b_data(%0d,%0d)", cx, cy), int'(d_b), model_px(f, cx, cy, 8));
        chk("a_x", int'(x_a), cx);
        chk("a_y", int'(y_a), cy);
        chk("a_sof", int'(sof_a), int'(out_idx == 0));
        chk("a_eof", int'(eof_a), int'(out_idx == N - 1));
        chk("b_dval", int'(dv_b), 1);
        chk("b_xy", int'(x_b) + 8 * int'(y_b), out_idx);
        cap_a[out_idx] = int'(d_a);
        cap_b[out_idx] = int'(d_b);
        out_idx++;
        outs++;
        if (out_idx == N) begin
          out_idx = 0;
          rd_f++;
        end
      end
    end
  end

  task automatic drive_pixel(input int d, input int m);
    int n;
    n = 0;
    iDVAL = 1'b1;
    da = 10'(d);
    iMODE = 2'(m);
    while (!rdy_a && n < 50) begin
      @(negedge iCLK);
      n++;
    end
    chk("ready_wait", int'(rdy_a), 1);
    @(negedge iCLK);
    iDVAL = 1'b0;
  endtask

  task automatic push_frame(input int pix[N], input int m0);
    fr_pix[wr_f % 16] = pix;
    fr_mode[wr_f % 16] = m0;
    wr_f++;
  endtask

  task automatic send_frame(input int pix[N], input int m0, input int tog, input int m1, input int gaps);
    push_frame(pix, m0);
    for (int i = 0; i < N; i++) begin
      if (gaps != 0 && $urandom_range(3) == 0) begin
        iDVAL = 1'b0;
        repeat ($urandom_range(3, 1)) begin
          da = 10'($urandom);
          iMODE = 2'($urandom);
          @(negedge iCLK);
        end
      end
      drive_pixel(pix[i], (tog >= 0 && i >= tog) ? m1 : m0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rd_f != wr_f && n < 400) begin
      @(negedge iCLK);
      n++;
    end
    chk("drain", rd_f, wr_f);
  endtask

  task automatic make_pat(input int pat, output int pix[N]);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: pix[i] = 300;
        1: pix[i] = ((i % W) < 4) ? 0 : 100;
        2: pix[i] = ((i % W) < 4) ? 0 : 200;
        default: pix[i] = int'($urandom_range(1023));
      endcase
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dval"}, int'(dv_a), 0);
    chk({tag, "_data"}, int'(d_a), 0);
    chk({tag, "_x"}, int'(x_a), 0);
    chk({tag, "_y"}, int'(y_a), 0);
    chk({tag, "_sof"}, int'(sof_a), 0);
    chk({tag, "_eof"}, int'(eof_a), 0);
    chk({tag, "_ready"}, int'(rdy_a), 1);
  endtask

  initial begin
    int pix [N];
    int o0, m0, m1;
    vt[0]  = '{0, 0, 3, 2, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0, 0};
    vt[2]  = '{0, 2, 7, 3, 0, 0};
    vt[3]  = '{0, 3, 5, 1, 300, 44};
    vt[4]  = '{1, 1, 3, 1, 400, B400};
    vt[5]  = '{1, 1, 4, 2, 400, B400};
    vt[6]  = '{1, 1, 0, 1, 0, 0};
    vt[7]  = '{1, 1, 7, 2, 0, 0};
    vt[8]  = '{1, 0, 3, 1, 0, 0};
    vt[9]  = '{1, 2, 4, 2, 400, B400};
    vt[10] = '{2, 1, 3, 1, 800, B800};
    vt[11] = '{2, 1, 4, 2, 800, B800};
    vt[12] = '{2, 3, 4, 1, 200, 200};

    repeat (3) @(negedge iCLK);
    check_reset_values("rst");
    iRST = 1'b0;

    for (int k = 0; k < 13; k++) begin
      make_pat(vt[k].pat, pix);
      send_frame(pix, vt[k].mode, -1, 0, 0);
      drain();
      chk($sformatf("vec%0d_a", k), cap_a[vt[k].row * W + vt[k].col], vt[k].exp_a);
      chk($sformatf("vec%0d_b", k), cap_b[vt[k].row * W + vt[k].col], vt[k].exp_b);
    end

    runs.delete();
    o0 = outs;
    make_pat(3, pix);
    send_frame(pix, 2, -1, 0, 0);
    make_pat(3, pix);
    send_frame(pix, 1, -1, 0, 0);
    drain();
    repeat (3) @(negedge iCLK);
    chk("flush_windows", runs.size(), 2);
    foreach (runs[i]) chk($sformatf("flush_len%0d", i), runs[i], 9);
    chk("outs_two_frames", outs - o0, 64);

    for (int k = 0; k < 4; k++) begin
      make_pat(3, pix);
      m0 = int'($urandom_range(3));
      m1 = (m0 + 1 + int'($urandom_range(2))) % 4;
      send_frame(pix, m0, int'($urandom_range(N - 2, 1)), m1, 1);
    end
    drain();

    make_pat(3, pix);
    push_frame(pix, 2);
    for (int i = 0; i < 13; i++) drive_pixel(pix[i], 2);
    iDVAL = 1'b1;
    da = 10'(pix[13]);
    iRST = 1'b1;
    @(negedge iCLK);
    check_reset_values("midrst");
    iRST = 1'b0;
    iDVAL = 1'b0;
    rd_f = wr_f;
    out_idx = 0;
    o0 = outs;
    make_pat(3, pix);
    send_frame(pix, 1, -1, 0, 1);
    drain();
    chk("outs_after_reset", outs - o0, N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
